// File: rtl/serial_adder_n.sv
// Bit-serial adder: one full-adder slice plus carry flop, WIDTH cycles per add, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic s_bit;
  logic c_next;

  always_comb begin
    s_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_next  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB; c_next is the carry out of it
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ c_next;
`endif
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: WIDTH=8 vectors, reset abort, back-to-back, WIDTH=3 sweep.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start3;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic       cin8, cin3;
  logic       busy8, done8, cout8;
  logic       busy3, done3, cout3;
  logic [7:0] sum8;
  logic [2:0] sum3;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_n #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operands are scrambled right after acceptance to show they were captured.
  task automatic add8(input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                      input logic [7:0] es, input logic ec, input string tag);
    int   n;
    logic busy_ok;
    a8 = aa; b8 = bb; cin8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~aa; b8 = ~bb; cin8 = ~ci;
    n = 0;
    busy_ok = 1'b1;
    while (!done8 && n < 20) begin
      if (!busy8) busy_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy"}, busy_ok, 1'b1);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_cout"}, cout8, ec);
    chk({tag, "_busy_at_done"}, busy8, 1'b0);
    tick();
    chk({tag, "_done_1cyc"}, done8, 1'b0);
  endtask

  initial begin
    int   pulses[$];
    logic saw_done;
    int   n;
    logic [3:0] exp3;

    rst = 1'b1;
    start8 = 1'b0; start3 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    a3 = 3'h0;  b3 = 3'h0;  cin3 = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
    chk("rst_sum3", {cout3, sum3}, 4'h0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf8, 1'b0);
`endif
    rst = 1'b0;
    tick();

    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
    add8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "5a_a5_c1");
    add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "12_34");
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ones_c1");
    add8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zeros");

    // Start held high: acceptance in DONE gives one result every 9 cycles.
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    for (int cyc = 0; cyc < 60 && pulses.size() < 3; cyc++) begin
      tick();
      if (done8) begin
        pulses.push_back(cyc);
        chk("b2b_sum", {cout8, sum8}, 9'h007);
      end
      if (done8 || !busy8) begin
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    chk("b2b_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("b2b_gap1", pulses[1] - pulses[0], 9);
      chk("b2b_gap2", pulses[2] - pulses[1], 9);
    end
    tick();
    chk("b2b_idle", busy8, 1'b0);

    // Reset mid-addition aborts it.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    chk("abort_busy_before", busy8, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    saw_done = 1'b0;
    repeat (15) begin
      tick();
      if (done8) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);
    add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_OVF_EN
    add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_7f");
    chk("ovf_7f_flag", ovf8, 1'b1);
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf_ff");
    chk("ovf_ff_flag", ovf8, 1'b0);
    add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "ovf_80");
    chk("ovf_80_flag", ovf8, 1'b1);
`endif

    // WIDTH=3 exhaustive sweep.
    for (int i = 0; i < 128; i++) begin
      a3 = 3'(i >> 4); b3 = 3'(i >> 1); cin3 = 1'(i);
      exp3 = 4'(a3) + 4'(b3) + 4'(cin3);
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      a3 = ~a3; b3 = ~b3;
      n = 0;
      while (!done3 && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("w3_lat_%0d", i), n, 3);
      chk($sformatf("w3_sum_%0d", i), {cout3, sum3}, exp3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
